// File: rtl/chi_slice_stage_if.sv
// Bus between the chi slice stage, the upstream slice store and the downstream slice buffer.
// The stage itself uses the slave modport; the surrounding controller/memories use master.
interface chi_slice_stage_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              start;
  logic              ready;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [24:0]       rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [24:0]       wr_data;
  logic              done;

  modport slave (
    input  start,
    input  rd_data,
    output ready,
    output rd_en,
    output rd_addr,
    output wr_en,
    output wr_addr,
    output wr_data,
    output done
  );

  modport master (
    output start,
    output rd_data,
    input  ready,
    input  rd_en,
    input  rd_addr,
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    input  done
  );
endinterface

// File: rtl/chi_slice_stage.sv
// Slice-serial Keccak-f chi step: reads one 25-bit slice per cycle, applies chi row-wise,
// and writes the result two cycles later into the buffer consumed by the iota stage.
module chi_slice_stage #(
  parameter int unsigned SLICES = 64,
  parameter int unsigned ADDR_W = 6
) (
  input logic               clk,
  input logic               rst,
  chi_slice_stage_if.slave  bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRun,
    StFlush1,
    StFlush2,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              v1_q, v1_d;
  logic [ADDR_W-1:0] a1_q, a1_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [24:0]       wr_data_q, wr_data_d;

  logic ready;
  logic rd_en;
  logic done;
  logic last_slice;

  // Bit 5*y+x of a slice is lane (x,y); chi mixes only within each 5-bit row.
  function automatic logic [24:0] chi(input logic [24:0] a);
    logic [24:0] r;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        r[5*y+x] = a[5*y+x] ^ (~a[5*y+((x+1)%5)] & a[5*y+((x+2)%5)]);
      end
    end
    return r;
  endfunction

  assign last_slice = (cnt_q == ADDR_W'(SLICES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (bus_io.start) state_d = StInit;
      StInit:   state_d = StRun;
      StRun:    if (last_slice) state_d = StFlush1;
      StFlush1: state_d = StFlush2;
      StFlush2: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    ready = 1'b0;
    rd_en = 1'b0;
    done  = 1'b0;
    unique case (state_q)
      StIdle:  ready = 1'b1;
      StRun:   rd_en = 1'b1;
      StDone:  done  = 1'b1;
      default: ;
    endcase
  end

  // Slice counter and read/compute/write pipeline next-state
  always_comb begin
    cnt_d     = cnt_q;
    v1_d      = rd_en;
    a1_d      = cnt_q;
    wr_en_d   = v1_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (state_q == StInit) begin
      cnt_d   = '0;
      v1_d    = 1'b0;
      wr_en_d = 1'b0;
    end else if (state_q == StRun) begin
      cnt_d = cnt_q + ADDR_W'(1);
    end

    // Write-side registers hold while idle; consumers qualify with wr_en.
    if (v1_q) begin
      wr_addr_d = a1_q;
      wr_data_d = chi(bus_io.rd_data);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= '0;
      v1_q      <= 1'b0;
      a1_q      <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      v1_q      <= v1_d;
      a1_q      <= a1_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus_io.ready   = ready;
  assign bus_io.rd_en   = rd_en;
  assign bus_io.rd_addr = cnt_q;
  assign bus_io.done    = done;
  assign bus_io.wr_en   = wr_en_q;
  assign bus_io.wr_addr = wr_addr_q;
  assign bus_io.wr_data = wr_data_q;

endmodule

// File: tb/tb_chi_slice_stage.sv
// Self-checking bench for chi_slice_stage: table vectors, random states against an
// arithmetic chi model, and hand-written start/reset corner sequences.
module tb_chi_slice_stage;

  localparam int unsigned SLICES = 64;
  localparam int unsigned ADDR_W = 6;

  typedef struct {
    int          slice;
    logic [24:0] din;
    logic [24:0] exp;
  } vec_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_total;
  int   n_pass;

  logic [24:0] mem [SLICES];

  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  int          wr_addr_q[$];
  logic [24:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          done_q[$];
  int          ready_q[$];
  logic        ready_prev;

  chi_slice_stage_if #(.ADDR_W(ADDR_W)) bus ();

  chi_slice_stage #(
    .SLICES(SLICES),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Upstream slice store: synchronous read
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
  end

  always @(negedge clk) begin
    if (bus.rd_en) begin
      rd_addr_q.push_back(int'(bus.rd_addr));
      rd_cyc_q.push_back(cyc);
    end
    if (bus.wr_en) begin
      wr_addr_q.push_back(int'(bus.wr_addr));
      wr_data_q.push_back(bus.wr_data);
      wr_cyc_q.push_back(cyc);
    end
    if (bus.done) done_q.push_back(cyc);
    if (bus.ready && !ready_prev) ready_q.push_back(cyc);
    ready_prev <= bus.ready;
  end

  // Reference chi: out bit = (a + (1 - b) * c) mod 2 over each row, indices mod 5.
  function automatic logic [24:0] ref_chi(input logic [24:0] s);
    logic [24:0] r;
    int a, b, c;
    r = '0;
    for (int y = 0; y < 5; y++) begin
      for (int x = 0; x < 5; x++) begin
        a = int'(s[5*y + x]);
        b = int'(s[5*y + (x + 1) % 5]);
        c = int'(s[5*y + (x + 2) % 5]);
        r[5*y + x] = 1'((a + (1 - b) * c) % 2);
      end
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_done(input int db, input int bound, input string tag);
    int n;
    n = 0;
    while (done_q.size() <= db && n < bound) begin
      @(negedge clk);
      #1;
      n++;
    end
    check({tag, " done within bound"}, 32'(done_q.size() > db), 32'd1);
  endtask

  task automatic start_run(output int s0, output int rb, output int wb, output int db);
    @(posedge clk);
    #1;
    s0 = cyc;
    rb = rd_addr_q.size();
    wb = wr_addr_q.size();
    db = done_q.size();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Full-run audit: counts, ordering, cycle timing and data against the reference model.
  task automatic check_run(input string tag, input int s0, input int rb, input int wb,
                           input int db);
    int bad_wr, bad_rd, nw, nr, rr;
    repeat (3) @(posedge clk);
    #1;
    nw = wr_addr_q.size() - wb;
    nr = rd_addr_q.size() - rb;
    check({tag, " write count"}, 32'(nw), 32'd64);
    check({tag, " read count"}, 32'(nr), 32'd64);
    bad_wr = 0;
    bad_rd = 0;
    for (int i = 0; i < 64 && i < nw; i++) begin
      if (wr_addr_q[wb+i] != i || wr_cyc_q[wb+i] != s0 + 4 + i) bad_wr++;
      check({tag, " wr_data"}, 32'(wr_data_q[wb+i]), 32'(ref_chi(mem[wr_addr_q[wb+i]])));
    end
    for (int i = 0; i < 64 && i < nr; i++) begin
      if (rd_addr_q[rb+i] != i || rd_cyc_q[rb+i] != s0 + 2 + i) bad_rd++;
    end
    check({tag, " write order/timing errors"}, 32'(bad_wr), 32'd0);
    check({tag, " read order/timing errors"}, 32'(bad_rd), 32'd0);
    check({tag, " done count"}, 32'(done_q.size() - db), 32'd1);
    if (done_q.size() > db) check({tag, " done cycle"}, 32'(done_q[db] - s0), 32'd68);
    rr = -1;
    foreach (ready_q[i]) if (rr < 0 && ready_q[i] > s0) rr = ready_q[i];
    check({tag, " ready return cycle"}, 32'(rr - s0), 32'd69);
  endtask

  initial begin
    vec_t vecs[6];
    int s0, rb, wb, db, found, bad, d1, d2, first_rd;

    n_total = 0;
    n_pass  = 0;
    cyc     = 0;
    ready_prev = 1'b0;
    bus.start  = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = '0;

    vecs[0] = '{0,  25'h1F0421,
                {5'b01001, 5'b01110, 5'b01001, 5'b01001, 5'b01001}};
    vecs[1] = '{5,  25'h0000001, 25'h0000009};
    vecs[2] = '{6,  {5{5'b00100}}, {5{5'b00101}}};
    vecs[3] = '{7,  25'h1FFFFFF, 25'h1FFFFFF};
    vecs[4] = '{63, {5'b00010, 5'b00011, 5'b00000, 5'b00010, 5'b00011},
                {5'b10010, 5'b01011, 5'b00000, 5'b10010, 5'b01011}};
    vecs[5] = '{62, {5{5'b00011}}, {5{5'b01011}}};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(bus.ready), 32'd1);
    check("reset rd_en", 32'(bus.rd_en), 32'd0);
    check("reset rd_addr", 32'(bus.rd_addr), 32'd0);
    check("reset wr_en", 32'(bus.wr_en), 32'd0);
    check("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    check("reset wr_data", 32'(bus.wr_data), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // All-zero state
    start_run(s0, rb, wb, db);
    wait_done(db, 100, "zero");
    check_run("zero", s0, rb, wb, db);
    check("zero ready low in done cycle", 32'(ready_q[ready_q.size()-1] > s0 + 68), 32'd1);

    // Table vectors
    foreach (vecs[k]) mem[vecs[k].slice] = vecs[k].din;
    start_run(s0, rb, wb, db);
    wait_done(db, 100, "table");
    check_run("table", s0, rb, wb, db);
    foreach (vecs[k]) begin
      found = 0;
      for (int i = wb; i < wr_addr_q.size(); i++) begin
        if (wr_addr_q[i] == vecs[k].slice) begin
          found++;
          check($sformatf("table slice %0d", vecs[k].slice), 32'(wr_data_q[i]),
                32'(vecs[k].exp));
        end
      end
      check($sformatf("table slice %0d write seen once", vecs[k].slice), 32'(found), 32'd1);
    end
    bad = 0;
    for (int i = wb; i < wr_addr_q.size(); i++) begin
      if (mem[wr_addr_q[i]] == '0 && wr_data_q[i] != '0) bad++;
    end
    check("table zero slices stay zero", 32'(bad), 32'd0);

    // Random states
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
      start_run(s0, rb, wb, db);
      wait_done(db, 100, "random");
      check_run($sformatf("random%0d", r), s0, rb, wb, db);
    end

    // start re-pulsed during Run and Flush1 is ignored
    start_run(s0, rb, wb, db);
    goto(s0 + 10);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    goto(s0 + 66);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(db, 100, "repulse");
    check_run("repulse", s0, rb, wb, db);
    repeat (10) @(posedge clk);
    #1;
    check("repulse no second run", 32'(done_q.size() - db), 32'd1);

    // Reset mid-Run
    for (int i = 0; i < 64; i++) mem[i] = 25'($urandom);
    start_run(s0, rb, wb, db);
    goto(s0 + 30);
    rst = 1'b1;
    #1;
    check("midrst ready", 32'(bus.ready), 32'd1);
    check("midrst rd_en", 32'(bus.rd_en), 32'd0);
    check("midrst wr_en", 32'(bus.wr_en), 32'd0);
    check("midrst done", 32'(bus.done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wb = wr_addr_q.size();
    repeat (5) @(posedge clk);
    #1;
    check("midrst no spurious write", 32'(wr_addr_q.size() - wb), 32'd0);
    start_run(s0, rb, wb, db);
    wait_done(db, 100, "after reset");
    check_run("after reset", s0, rb, wb, db);

    // start held high: back-to-back runs
    @(posedge clk);
    #1;
    s0 = cyc;
    db = done_q.size();
    bus.start = 1'b1;
    wait_done(db, 100, "held first");
    wait_done(db + 1, 100, "held second");
    bus.start = 1'b0;
    d1 = (done_q.size() > db) ? done_q[db] : -1;
    d2 = (done_q.size() > db + 1) ? done_q[db+1] : -1;
    check("held first done cycle", 32'(d1 - s0), 32'd68);
    check("held done spacing", 32'(d2 - d1), 32'd69);
    first_rd = -1;
    foreach (rd_cyc_q[i]) begin
      if (first_rd < 0 && rd_cyc_q[i] > d1) begin
        first_rd = rd_cyc_q[i];
        check("held second run starts at slice 0", 32'(rd_addr_q[i]), 32'd0);
      end
    end
    check("held second run first read cycle", 32'(first_rd - d1), 32'd3);
    repeat (80) @(posedge clk);
    #1;
    check("held exactly two runs", 32'(done_q.size() - db), 32'd2);
    check("held ends in idle", 32'(bus.ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

endmodule
